// File: rtl/lynxTypes.sv
// Shared types for the RDMA ACK/NAK meta path and the ACK coalescer.
// Key equality deliberately ignores nak and cnt: only (vfid, pid, rd) identify a group.
package lynxTypes;

    localparam int RDMA_ACK_CNT_BITS = 4;
    localparam int RDMA_VFID_BITS    = 4;
    localparam int RDMA_PID_BITS     = 6;

    typedef struct packed {
        logic [RDMA_VFID_BITS-1:0] vfid;
        logic [RDMA_PID_BITS-1:0]  pid;
        logic                      rd;
        logic                      nak;
    } rdma_ack_t;

    typedef struct packed {
        rdma_ack_t                    ack;
        logic [RDMA_ACK_CNT_BITS-1:0] cnt;
    } rdma_ack_coal_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACC   = 1'b1
    } coal_state_e;

    function automatic logic rdma_ack_key_eq(rdma_ack_t a, rdma_ack_t b);
        return (a.vfid == b.vfid) && (a.pid == b.pid) && (a.rd == b.rd);
    endfunction

endpackage

// File: rtl/rdma_coal_timer.sv
// Saturating idle counter for the coalescer accumulator.
// expire_o stays high once the count reaches TIMEOUT-1 until the next clear.
module rdma_coal_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic aclk,
    input  logic areset,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/rdma_ack_coalescer.sv
// Merges back-to-back ACKs sharing (vfid, pid, rd) into one beat with a count.
// NAKs and beats loaded while coal_en=0 are marked forced: they never merge and flush next cycle.
module rdma_ack_coalescer
    import lynxTypes::*;
#(
    parameter int TIMEOUT  = 16,
    parameter int MAX_COAL = 8
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic           coal_en,
    input  logic           s_ack_valid,
    output logic           s_ack_ready,
    input  rdma_ack_t      s_ack_data,
    output logic           m_ack_valid,
    input  logic           m_ack_ready,
    output rdma_ack_coal_t m_ack_data,
    output logic [31:0]    stat_merged
);

    localparam int                 CW      = RDMA_ACK_CNT_BITS;
    localparam logic [CW-1:0]      MAX_CNT = CW'(MAX_COAL);

    coal_state_e    state_q, state_d;
    rdma_ack_t      acc_q, acc_d;
    logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
    logic           acc_force_q, acc_force_d;
    logic           out_v_q, out_v_d;
    rdma_ack_coal_t out_q, out_d;
    logic [31:0]    stat_q, stat_d;

    logic acc_v;
    logic out_free;
    logic merge_ok;
    logic accept;
    logic flush;
    logic timer_clr;
    logic timer_inc;
    logic timer_expire;

    rdma_coal_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .aclk     (aclk),
        .areset   (areset),
        .clr_i    (timer_clr),
        .inc_i    (timer_inc),
        .expire_o (timer_expire)
    );

    assign acc_v    = (state_q == ST_ACC);
    assign out_free = !out_v_q || m_ack_ready;
    assign merge_ok = acc_v && !acc_force_q && coal_en && !s_ack_data.nak &&
                      rdma_ack_key_eq(s_ack_data, acc_q) && (acc_cnt_q < MAX_CNT);
    // A non-mergeable beat is only taken when acc can move to out in the same edge.
    assign s_ack_ready = !areset && (!acc_v || merge_ok || out_free);
    assign accept      = s_ack_valid && s_ack_ready;
    assign flush       = acc_v && !accept && out_free &&
                         (acc_force_q || (acc_cnt_q == MAX_CNT) || timer_expire);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        acc_force_d = acc_force_q;
        out_v_d     = out_v_q;
        out_d       = out_q;
        stat_d      = stat_q;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;

        if (out_v_q && m_ack_ready) begin
            out_v_d = 1'b0;
        end

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    acc_d       = s_ack_data;
                    acc_cnt_d   = CW'(1);
                    acc_force_d = s_ack_data.nak || !coal_en;
                    timer_clr   = 1'b1;
                    state_d     = ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept && merge_ok) begin
                    acc_cnt_d = acc_cnt_q + CW'(1);
                    stat_d    = stat_q + 32'd1;
                    timer_clr = 1'b1;
                end else if (accept) begin
                    out_d       = '{ack: acc_q, cnt: acc_cnt_q};
                    out_v_d     = 1'b1;
                    acc_d       = s_ack_data;
                    acc_cnt_d   = CW'(1);
                    acc_force_d = s_ack_data.nak || !coal_en;
                    timer_clr   = 1'b1;
                end else if (flush) begin
                    out_d   = '{ack: acc_q, cnt: acc_cnt_q};
                    out_v_d = 1'b1;
                    state_d = ST_EMPTY;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_EMPTY;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            acc_force_q <= 1'b0;
            out_v_q     <= 1'b0;
            out_q       <= '0;
            stat_q      <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_force_q <= acc_force_d;
            out_v_q     <= out_v_d;
            out_q       <= out_d;
            stat_q      <= stat_d;
        end
    end

    assign m_ack_valid = out_v_q;
    assign m_ack_data  = out_q;
    assign stat_merged = stat_q;

endmodule

// File: tb/tb_rdma_ack_coalescer.sv
// Directed + randomized bench for rdma_ack_coalescer; inputs driven on the falling edge,
// outputs collected by a monitor shortly after the falling edge.
module tb_rdma_ack_coalescer;
    import lynxTypes::*;

    localparam int TIMEOUT  = 16;
    localparam int MAX_COAL = 8;

    logic           aclk        = 1'b0;
    logic           areset      = 1'b1;
    logic           coal_en     = 1'b1;
    logic           s_ack_valid = 1'b0;
    logic           s_ack_ready;
    rdma_ack_t      s_ack_data  = '0;
    logic           m_ack_valid;
    logic           m_ack_ready = 1'b1;
    rdma_ack_coal_t m_ack_data;
    logic [31:0]    stat_merged;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;
    int exp_merged = 0;

    rdma_ack_t      inq[$];
    rdma_ack_coal_t outq[$];
    rdma_ack_coal_t expq[$];

    rdma_ack_coalescer #(
        .TIMEOUT  (TIMEOUT),
        .MAX_COAL (MAX_COAL)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .coal_en     (coal_en),
        .s_ack_valid (s_ack_valid),
        .s_ack_ready (s_ack_ready),
        .s_ack_data  (s_ack_data),
        .m_ack_valid (m_ack_valid),
        .m_ack_ready (m_ack_ready),
        .m_ack_data  (m_ack_data),
        .stat_merged (stat_merged)
    );

    always #5 aclk = ~aclk;

    // Valid&ready seen in the low phase means the beat transfers on the next rising edge.
    always begin
        @(negedge aclk);
        #2;
        if (!areset && m_ack_valid && m_ack_ready) begin
            outq.push_back(m_ack_data);
            $display("[%0t] out vfid=%0d pid=%0d rd=%0d nak=%0d cnt=%0d", $time,
                     m_ack_data.ack.vfid, m_ack_data.ack.pid, m_ack_data.ack.rd,
                     m_ack_data.ack.nak, m_ack_data.cnt);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic rdma_ack_t mk(int vfid, int pid, int rd, int nak);
        rdma_ack_t b;
        b.vfid = 4'(vfid);
        b.pid  = 6'(pid);
        b.rd   = 1'(rd);
        b.nak  = 1'(nak);
        return b;
    endfunction

    function automatic rdma_ack_t rnd_beat(int vmax, int nak_den);
        return mk($urandom_range(0, vmax), $urandom_range(0, 1), 0,
                  ($urandom_range(0, nak_den - 1) == 0) ? 1 : 0);
    endfunction

    // Called in the low phase; returns at the falling edge after the accepting edge.
    task automatic send(input rdma_ack_t b);
        int w;
        s_ack_valid = 1'b1;
        s_ack_data  = b;
        #1;
        w = 0;
        while (!s_ack_ready && w < 300) begin
            stalls++;
            @(negedge aclk);
            #1;
            w++;
        end
        if (!s_ack_ready) begin
            chk("send_timeout", 64'(s_ack_ready), 64'(1));
            s_ack_valid = 1'b0;
            @(negedge aclk);
        end else begin
            @(posedge aclk);
            inq.push_back(b);
            $display("[%0t] in  vfid=%0d pid=%0d rd=%0d nak=%0d", $time, b.vfid, b.pid, b.rd, b.nak);
            @(negedge aclk);
        end
    endtask

    task automatic idle();
        s_ack_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input int bound);
        int c = 0;
        while (outq.size() < n && c < bound) begin
            @(negedge aclk);
            #3;
            c++;
        end
        @(negedge aclk);
    endtask

    // Edges counted from the acceptance edge (inclusive) until m_ack_valid is seen.
    task automatic measure(output int edges);
        int k = 0;
        idle();
        while (!m_ack_valid && k < 100) begin
            @(negedge aclk);
            k++;
        end
        edges = k + 1;
    endtask

    function automatic int outsum();
        int s = 0;
        foreach (outq[i]) s += int'(outq[i].cnt);
        return s;
    endfunction

    // Grouping for a gap-free stream with an always-ready sink: greedy runs capped at MAX_COAL.
    function automatic void build_greedy(bit coal);
        rdma_ack_coal_t g;
        int last;
        expq.delete();
        foreach (inq[i]) begin
            last = expq.size() - 1;
            if (coal && last >= 0 && !expq[last].ack.nak && !inq[i].nak &&
                expq[last].ack.vfid == inq[i].vfid && expq[last].ack.pid == inq[i].pid &&
                expq[last].ack.rd == inq[i].rd && int'(expq[last].cnt) < MAX_COAL) begin
                expq[last].cnt = expq[last].cnt + 4'd1;
            end else begin
                g.ack = inq[i];
                g.cnt = 4'd1;
                expq.push_back(g);
            end
        end
    endfunction

    task automatic compare_exact(input string tag);
        int n;
        chk({tag, "_beats"}, 64'(outq.size()), 64'(expq.size()));
        n = (outq.size() < expq.size()) ? outq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_ack"}, 64'(outq[i].ack), 64'(expq[i].ack));
            chk({tag, "_cnt"}, 64'(outq[i].cnt), 64'(expq[i].cnt));
        end
        foreach (expq[i]) exp_merged += int'(expq[i].cnt) - 1;
        chk({tag, "_stat"}, 64'(stat_merged), 64'(exp_merged));
    endtask

    // Timing-independent rule: outputs expand, in order, to the exact input stream.
    task automatic check_expand(input string tag);
        int idx = 0;
        foreach (outq[i]) begin
            chk({tag, "_cnt_range"}, 64'((outq[i].cnt >= 1) && (int'(outq[i].cnt) <= MAX_COAL)), 64'(1));
            if (outq[i].ack.nak) chk({tag, "_nak_alone"}, 64'(outq[i].cnt), 64'(1));
            for (int j = 0; j < int'(outq[i].cnt); j++) begin
                if (idx < inq.size()) begin
                    chk({tag, "_member"}, 64'(outq[i].ack), 64'(inq[idx]));
                end
                idx++;
            end
        end
        chk({tag, "_total"}, 64'(idx), 64'(inq.size()));
    endtask

    task automatic start_test();
        inq.delete();
        outq.delete();
        stalls = 0;
    endtask

    initial begin
        int e;
        int stat_before;

        // Reset state
        @(negedge aclk);
        chk("rst_s_ready", 64'(s_ack_ready), 64'(0));
        chk("rst_m_valid", 64'(m_ack_valid), 64'(0));
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("rst_stat", 64'(stat_merged), 64'(0));
        chk("rst_ready_after", 64'(s_ack_ready), 64'(1));
        @(negedge aclk);

        // Three same-key ACKs: one beat after the idle timeout
        start_test();
        repeat (3) send(mk(1, 5, 0, 0));
        measure(e);
        chk("t3_latency", 64'(e), 64'(TIMEOUT + 1));
        wait_out(1, 10);
        build_greedy(1'b1);
        compare_exact("t3");

        // Exactly MAX_COAL ACKs: full accumulation flushes without waiting
        start_test();
        repeat (MAX_COAL) send(mk(2, 1, 1, 0));
        measure(e);
        chk("tmax_latency", 64'(e), 64'(2));
        wait_out(1, 10);
        build_greedy(1'b1);
        compare_exact("tmax");

        // Ten same-key ACKs: 8 then 2, no stall
        start_test();
        repeat (10) send(mk(3, 7, 0, 0));
        idle();
        chk("t10_no_stall", 64'(stalls), 64'(0));
        wait_out(2, TIMEOUT + 20);
        build_greedy(1'b1);
        compare_exact("t10");

        // Alternating keys: four lone beats in order
        start_test();
        for (int i = 0; i < 4; i++) send(mk((i % 2) + 1, 5, 0, 0));
        idle();
        chk("talt_no_stall", 64'(stalls), 64'(0));
        wait_out(4, TIMEOUT + 20);
        build_greedy(1'b1);
        compare_exact("talt");

        // ACK then NAK of the same key: both leave without a timeout wait
        start_test();
        send(mk(0, 3, 0, 0));
        send(mk(0, 3, 0, 1));
        idle();
        wait_out(2, 3);
        build_greedy(1'b1);
        compare_exact("tnak");

        // Coalescing disabled: every beat forced
        coal_en = 1'b0;
        start_test();
        send(mk(4, 2, 0, 0));
        measure(e);
        chk("tdis_latency", 64'(e), 64'(2));
        repeat (3) send(mk(4, 2, 0, 0));
        idle();
        wait_out(4, 10);
        build_greedy(1'b0);
        compare_exact("tdis");
        coal_en = 1'b1;

        // Random gap-free stream against the greedy grouping model
        start_test();
        for (int i = 0; i < 40; i++) send(rnd_beat(1, 8));
        idle();
        build_greedy(1'b1);
        wait_out(expq.size(), TIMEOUT + 60);
        chk("trnd_no_stall", 64'(stalls), 64'(0));
        compare_exact("trnd");

        // Backpressure: sink stalled 50 cycles while 20 random beats are offered
        start_test();
        stat_before = int'(stat_merged);
        m_ack_ready = 1'b0;
        fork
            begin
                repeat (50) @(negedge aclk);
                m_ack_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 20; i++) send(rnd_beat(1, 6));
                idle();
            end
        join
        begin
            int c = 0;
            while (outsum() < 20 && c < TIMEOUT + 100) begin
                @(negedge aclk);
                #3;
                c++;
            end
        end
        @(negedge aclk);
        chk("tbp_stalled", 64'(stalls > 0), 64'(1));
        chk("tbp_cnt_sum", 64'(outsum()), 64'(20));
        check_expand("tbp");
        chk("tbp_stat", 64'(int'(stat_merged) - stat_before), 64'(20 - outq.size()));

        // Reset with a held output beat and an accumulation of 4
        start_test();
        m_ack_ready = 1'b0;
        send(mk(5, 1, 0, 0));
        repeat (4) send(mk(6, 1, 0, 0));
        idle();
        chk("trst_held_valid", 64'(m_ack_valid), 64'(1));
        areset = 1'b1;
        #1;
        chk("trst_valid_now", 64'(m_ack_valid), 64'(0));
        chk("trst_ready_now", 64'(s_ack_ready), 64'(0));
        m_ack_ready = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        repeat (TIMEOUT + 15) @(negedge aclk);
        #3;
        chk("trst_no_output", 64'(outq.size()), 64'(0));
        chk("trst_stat", 64'(stat_merged), 64'(0));
        exp_merged = 0;

        // Fresh traffic after reset still works
        @(negedge aclk);
        start_test();
        repeat (2) send(mk(7, 9, 1, 0));
        idle();
        wait_out(1, TIMEOUT + 10);
        build_greedy(1'b1);
        compare_exact("tpost");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
